rx_capture_core: RTL

// - Receive-side counterpart of the TX DSP path. Watches the parallel ADC super-sample

---
 rtl/rx_capture_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rx_capture_core.sv
// ADC capture core: threshold trigger, RAM capture of N super-sample words,
// valid/ready readout with last flag, and peak |sample| reporting.
module rx_capture_core #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         arm,
  input  logic [15:0]                  threshold,
  input  logic [ADDR_WIDTH:0]          capture_length,
  input  logic [16*NUMBER_OF_LINE-1:0] adc_data,
  output logic [16*NUMBER_OF_LINE-1:0] m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic                         busy,
  output logic                         triggered,
  output logic [15:0]                  interval_max
);

  localparam int DW = 16 * NUMBER_OF_LINE;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_READOUT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0] len_q, len_d;
  logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0] rd_cnt_q, rd_cnt_d;
  logic [15:0]         peak_q, peak_d;
  logic [15:0]         imax_q, imax_d;
  logic [DW-1:0]       tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;

  logic [DW-1:0] mem [DEPTH];

  logic                trig;
  logic [15:0]         word_peak;
  logic [15:0]         new_peak;
  logic                wr_en;
  logic                last_wr;
  logic                load;
  logic [ADDR_WIDTH:0] len_sat;

  // |-32768| has no 16-bit signed magnitude, so it clips to 32767
  function automatic logic [15:0] mag(input logic [15:0] s);
    if (!s[15]) return s;
    if (s == 16'h8000) return 16'h7fff;
    return -s;
  endfunction

  always_comb begin
    trig      = 1'b0;
    word_peak = '0;
    for (int i = 0; i < NUMBER_OF_LINE; i++) begin
      if ($signed(adc_data[16*i +: 16]) > $signed(threshold))
        trig = 1'b1;
      if (mag(adc_data[16*i +: 16]) > word_peak)
        word_peak = mag(adc_data[16*i +: 16]);
    end
  end

  assign len_sat = (capture_length == '0 || capture_length > DEPTH_W)
                 ? DEPTH_W : capture_length;
  assign wr_en   = (state_q == S_ARMED && trig) || state_q == S_CAPTURE;
  assign last_wr = (wr_cnt_q + 1'b1) == len_q;
  assign load    = state_q == S_READOUT && rd_cnt_q != len_q
                 && (!tvalid_q || m_tready);
  assign new_peak = (word_peak > peak_q) ? word_peak : peak_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arm) state_d = S_ARMED;
      S_ARMED:   if (trig) state_d = last_wr ? S_READOUT : S_CAPTURE;
      S_CAPTURE: if (last_wr) state_d = S_READOUT;
      S_READOUT: if (tvalid_q && m_tready && tlast_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = state_q != S_IDLE;
    triggered = state_q == S_CAPTURE || state_q == S_READOUT;
  end

  always_comb begin
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    peak_d   = peak_q;
    imax_d   = imax_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (state_q == S_IDLE) begin
      wr_cnt_d = '0;
      if (arm) begin
        len_d  = len_sat;
        peak_d = '0;
      end
    end else if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      peak_d   = new_peak;
      if (last_wr) imax_d = new_peak;
    end
    if (state_q != S_READOUT) begin
      rd_cnt_d = '0;
    end else if (load) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      tdata_d  = mem[rd_cnt_q[ADDR_WIDTH-1:0]];
      tvalid_d = 1'b1;
      tlast_d  = (rd_cnt_q + 1'b1) == len_q;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      peak_q   <= '0;
      imax_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      peak_q   <= peak_d;
      imax_q   <= imax_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_cnt_q[ADDR_WIDTH-1:0]] <= adc_data;
  end

  assign m_tdata      = tdata_q;
  assign m_tvalid     = tvalid_q;
  assign m_tlast      = tlast_q;
  assign interval_max = imax_q;

endmodule
